bit_vault: RTL and testbench

- Small synchronous-write, asynchronous-read register file: 4 entries × 8 bits by default.
- Used as a scratch/config store. A producer writes one entry per clock; any consumer reads the addressed entry combinationally.
- Contents are cleared by a synchronous, active-high reset.
- No handshake. Writes complete in one cycle.

---
 rtl/bit_vault_if.sv | 25 ++
 rtl/bit_vault.sv | 27 ++
 tb/tb_bit_vault.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bit_vault_if.sv
// Producer-facing port bundle for the bit_vault register file.
// No handshake: a write takes effect on the rising edge where we=1, and data_out always reflects entry[addr].
interface bit_vault_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              we;
  logic [DATA_W-1:0] data_out;

  modport master (
    output addr,
    output data_in,
    output we,
    input  data_out
  );

  modport slave (
    input  addr,
    input  data_in,
    input  we,
    output data_out
  );
endinterface

// File: rtl/bit_vault.sv
// Small register file: synchronous write, asynchronous read, cleared by synchronous reset.
// Reset wins over a write in the same cycle; reads never bypass data_in.
module bit_vault #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  bit_vault_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.we) begin
      mem[bus.addr] <= bus.data_in;
    end
  end

  // The address fully decodes every entry, so no range check is needed.
  assign bus.data_out = mem[bus.addr];
endmodule

// File: tb/tb_bit_vault.sv
// Directed bench for bit_vault: an array model checked every cycle plus literal read expectations.
module tb_bit_vault;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit_vault_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_i ();

  bit_vault #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: plain array of entry contents
  logic [DATA_W-1:0] model_mem [DEPTH];
  bit model_known = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else if (bus_i.we) begin
      model_mem[bus_i.addr] = bus_i.data_in;
    end
  end

  // every-cycle compare against the model, mid-cycle
  always @(negedge clk) begin
    if (model_known) begin
      n_checks++;
      if (bus_i.data_out !== model_mem[bus_i.addr]) begin
        n_fail++;
        $display("FAIL cycle_read addr=%0d: got %h expected %h",
                 bus_i.addr, bus_i.data_out, model_mem[bus_i.addr]);
      end
    end
  end

  // scoreboard for hand-computed literal expectations
  logic [DATA_W-1:0] exp_q[$];

  task automatic check_lit(input string name);
    logic [DATA_W-1:0] exp;
    exp = exp_q.pop_front();
    n_checks++;
    if (bus_i.data_out !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, bus_i.data_out, exp);
    end
  endtask

  // driver tasks: inputs change at posedge+1
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus_i.addr    = a;
    bus_i.data_in = d;
    bus_i.we      = 1'b1;
    @(posedge clk);
    #1;
    bus_i.we      = 1'b0;
  endtask

  task automatic rd_expect(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp,
                           input string name);
    bus_i.addr = a;
    bus_i.we   = 1'b0;
    exp_q.push_back(exp);
    #1;
    check_lit(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus_i.we      = 1'b1;
    bus_i.addr    = '0;
    bus_i.data_in = 8'hFF;

    // reset clear, with a competing write request
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus_i.we    = 1'b0;
    model_known = 1'b1;
    for (int a = 0; a < DEPTH; a++) rd_expect(a[ADDR_W-1:0], 8'h00, "reset_clear");

    // write / readback
    wr(2'd0, 8'hAA);
    wr(2'd2, 8'h55);
    rd_expect(2'd0, 8'hAA, "readback_a0");
    rd_expect(2'd2, 8'h55, "readback_a2");
    rd_expect(2'd1, 8'h00, "readback_a1");
    rd_expect(2'd3, 8'h00, "readback_a3");

    // write protection: data_in toggling with we=0
    bus_i.addr    = 2'd2;
    bus_i.data_in = 8'hFF;
    repeat (3) begin
      @(posedge clk);
      #1;
      bus_i.data_in = ~bus_i.data_in;
    end
    rd_expect(2'd2, 8'h55, "protect_a2");
    rd_expect(2'd0, 8'hAA, "protect_a0");

    // read-during-write: old value before the edge, new value after
    bus_i.addr    = 2'd1;
    bus_i.data_in = 8'h3C;
    bus_i.we      = 1'b1;
    exp_q.push_back(8'h00);
    #1;
    check_lit("rdw_before");
    @(posedge clk);
    #1;
    exp_q.push_back(8'h3C);
    check_lit("rdw_after");
    bus_i.we = 1'b0;

    // overwrite and full sweep
    wr(2'd0, 8'h11);
    wr(2'd1, 8'h22);
    wr(2'd2, 8'h33);
    wr(2'd3, 8'h44);
    wr(2'd3, 8'hC3);
    rd_expect(2'd0, 8'h11, "sweep_a0");
    rd_expect(2'd1, 8'h22, "sweep_a1");
    rd_expect(2'd2, 8'h33, "sweep_a2");
    rd_expect(2'd3, 8'hC3, "sweep_a3");

    // reset mid-operation overrides a write
    rst           = 1'b1;
    bus_i.we      = 1'b1;
    bus_i.addr    = 2'd0;
    bus_i.data_in = 8'hEE;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus_i.we = 1'b0;
    for (int a = 0; a < DEPTH; a++) rd_expect(a[ADDR_W-1:0], 8'h00, "midreset_clear");

    // normal write right after reset
    wr(2'd2, 8'h5A);
    rd_expect(2'd2, 8'h5A, "post_reset_write");
    rd_expect(2'd0, 8'h00, "post_reset_a0");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
